ext_bus_arbiter: RTL and testbench

Parametrised external-bus controller that arbitrates NUM_CH requesters onto one shared memory port. The memory port drives the data RAM and the instruction ROM.
Requesters are, for example, the instruction-fetch path and the MAR/MBR data path.
- Round-robin grant.
- Req/ack handshake toward each requester.
- Configurable memory read latency.
- Write protection on instruction space.
Sits between the internal register file and the memories, in place of the fixed two-source bus.

---
 rtl/ext_bus_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_ext_bus_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_bus_arbiter.sv
// ext_bus_arbiter
//   Round-robin arbiter that multiplexes NUM_CH requesters onto one shared
//   memory port which drives the data RAM and the instruction ROM.
//   Each transaction: IDLE (arbitrate/latch) -> ACCESS (one strobe cycle)
//   -> WAIT (reads only, WAIT_CYCLES cycles) -> RESP (one-cycle ack).
//   Writes to instruction space are rejected with o_err in the ack cycle.
//
// Optional feature (macro EXT_BUS_PERF_CNT_EN):
//   adds o_perf_xfers / o_perf_stall saturating 16-bit counters.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_req/i_we/i_space  per-channel request, write enable, target space
//   i_addr/i_wdata      per-channel address / write data, channel k at [k*W +: W]
//   o_ack               one-cycle completion pulse to the granted channel
//   o_err               rejected access, valid with ack
//   o_rdata             read data, updated only by completed reads
//   o_busy              high whenever not idle
//   o_grant_id          current or last granted channel
//   o_mem_addr/o_mem_wdata        shared memory address / write data
//   o_data_ram_write/o_data_ram_read/o_instr_rom_read  memory strobes
//   i_data/i_instr      data RAM / instruction ROM read data
//   o_perf_xfers/o_perf_stall     performance counters (macro only)
module ext_bus_arbiter #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_CH-1:0]        i_req,
  input  logic [NUM_CH-1:0]        i_we,
  input  logic [NUM_CH-1:0]        i_space,
  input  logic [NUM_CH*ADDR_W-1:0] i_addr,
  input  logic [NUM_CH*DATA_W-1:0] i_wdata,
  output logic [NUM_CH-1:0]        o_ack,
  output logic                     o_err,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_busy,
  output logic [2:0]               o_grant_id,
  output logic [ADDR_W-1:0]        o_mem_addr,
  output logic [DATA_W-1:0]        o_mem_wdata,
  output logic                     o_data_ram_write,
  output logic                     o_data_ram_read,
  output logic                     o_instr_rom_read,
`ifdef EXT_BUS_PERF_CNT_EN
  output logic [15:0]              o_perf_xfers,
  output logic [15:0]              o_perf_stall,
`endif
  input  logic [DATA_W-1:0]        i_data,
  input  logic [DATA_W-1:0]        i_instr
);

  localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  logic [1:0]        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [2:0]        grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              space_q, space_d;
  logic              err_q, err_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    int unsigned idx;
    int unsigned win;
    logic        found;

    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    space_d = space_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    idx     = 0;
    win     = 0;
    found   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // First requester at or above the pointer, wrapping around.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          idx = (32'(ptr_q) + i) % NUM_CH;
          if (!found && i_req[idx]) begin
            found = 1'b1;
            win   = idx;
          end
        end
        if (found) begin
          addr_d  = i_addr[win*ADDR_W +: ADDR_W];
          wdata_d = i_wdata[win*DATA_W +: DATA_W];
          we_d    = i_we[win];
          space_d = i_space[win];
          grant_d = 3'(win);
          ptr_d   = PTR_W'((win + 1) % NUM_CH);
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (we_q) begin
          // Instruction-space writes are rejected without any strobe.
          err_d   = space_q;
          state_d = ST_RESP;
        end else begin
          cnt_d   = WAIT_LD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          rdata_d = space_q ? i_instr : i_data;
          state_d = ST_RESP;
        end
      end
      default: begin
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      space_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      space_q <= space_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    o_ack = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      o_ack[k] = (state_q == ST_RESP) && (grant_q == 3'(k));
    end
  end

  // Strobes decode directly from state so an async reset drops them at once.
  assign o_data_ram_write = (state_q == ST_ACCESS) &&  we_q && !space_q;
  assign o_data_ram_read  = (state_q == ST_ACCESS) && !we_q && !space_q;
  assign o_instr_rom_read = (state_q == ST_ACCESS) && !we_q &&  space_q;
  assign o_err            = (state_q == ST_RESP) && err_q;
  assign o_busy           = (state_q != ST_IDLE);
  assign o_rdata          = rdata_q;
  assign o_grant_id       = grant_q;
  assign o_mem_addr       = addr_q;
  assign o_mem_wdata      = wdata_q;

`ifdef EXT_BUS_PERF_CNT_EN
  logic [15:0] xfers_q, stall_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      xfers_q <= '0;
      stall_q <= '0;
    end else begin
      if ((state_q == ST_RESP) && (xfers_q != '1)) begin
        xfers_q <= xfers_q + 16'd1;
      end
      if (((i_req & ~o_ack) != '0) && (stall_q != '1)) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

  assign o_perf_xfers = xfers_q;
  assign o_perf_stall = stall_q;
`endif

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// tb_ext_bus_arbiter
//   Scoreboard bench for ext_bus_arbiter. The driver builds per-channel
//   transaction lists, predicts service order (round robin over channels
//   with pending work), ack cycles, strobes and read data from a
//   transaction-level model, and pushes expectations into queues. A separate
//   monitor pops and compares on every strobe and every ack.
`timescale 1ns/1ps
module tb_ext_bus_arbiter;
  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 8;
  localparam int unsigned NCH = 3;
  localparam int unsigned WC  = 2;

  typedef struct {
    logic           we;
    logic           space;
    logic [AW-1:0]  a;
    logic [DW-1:0]  d;
  } txn_t;

  typedef struct {
    int             cyc;
    int             ch;
    logic           err;
    logic [DW-1:0]  rdata;
  } ackexp_t;

  typedef struct {
    int             cyc;
    int             kind;   // 0 ram write, 1 ram read, 2 rom read
    logic [AW-1:0]  a;
    logic [DW-1:0]  d;
  } strexp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [NCH-1:0]     req = '0, we = '0, space = '0;
  logic [NCH*AW-1:0]  addr = '0;
  logic [NCH*DW-1:0]  wdata = '0;
  logic [NCH-1:0]     o_ack;
  logic               o_err, o_busy;
  logic [DW-1:0]      o_rdata, o_mem_wdata, i_data, i_instr;
  logic [2:0]         o_grant_id;
  logic [AW-1:0]      o_mem_addr;
  logic               o_data_ram_write, o_data_ram_read, o_instr_rom_read;
`ifdef EXT_BUS_PERF_CNT_EN
  logic [15:0]        o_perf_xfers, o_perf_stall;
`endif

  ext_bus_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_CH(NCH), .WAIT_CYCLES(WC)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_space(space),
    .i_addr(addr), .i_wdata(wdata), .o_ack(o_ack), .o_err(o_err),
    .o_rdata(o_rdata), .o_busy(o_busy), .o_grant_id(o_grant_id),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_data_ram_write(o_data_ram_write), .o_data_ram_read(o_data_ram_read),
    .o_instr_rom_read(o_instr_rom_read),
`ifdef EXT_BUS_PERF_CNT_EN
    .o_perf_xfers(o_perf_xfers), .o_perf_stall(o_perf_stall),
`endif
    .i_data(i_data), .i_instr(i_instr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
    return {a, ~a} ^ 16'h3C00;
  endfunction

  function automatic logic [DW-1:0] ram_init(input int i);
    return DW'(i * 7 + 3);
  endfunction

  // Environment memories driven by the DUT memory port.
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) ram[i] <= ram_init(i);
    end else if (o_data_ram_write) begin
      ram[o_mem_addr] <= o_mem_wdata;
    end
  end
  assign i_data  = ram[o_mem_addr];
  assign i_instr = rom_val(o_mem_addr);

  // Scoreboard state
  ackexp_t ack_q[$];
  strexp_t str_q[$];
  int      checks = 0, failures = 0;
  int      drv_timeouts = 0;
  int      exp_xfers = 0;
  logic    done = 1'b0;

  // Reference model state
  logic [DW-1:0] ref_ram [256];
  logic [DW-1:0] lastrd;
  int            model_ptr;
  txn_t          chq [NCH][$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    ackexp_t ea;
    strexp_t es;
    int      nstb;
    int      kind;
    while (!done) begin
      @(negedge clk);
      if (!done) begin
        if (!rst_n) begin
          chk("reset_outputs",
              64'({o_busy, o_ack, o_err, o_data_ram_write, o_data_ram_read,
                   o_instr_rom_read, o_rdata, o_grant_id, o_mem_addr, o_mem_wdata}),
              64'(0));
`ifdef EXT_BUS_PERF_CNT_EN
          chk("reset_perf", 64'({o_perf_xfers, o_perf_stall}), 64'(0));
`endif
        end else begin
          nstb = int'(o_data_ram_write) + int'(o_data_ram_read) + int'(o_instr_rom_read);
          if (nstb != 0) begin
            chk("one_strobe", 64'(nstb), 64'(1));
            kind = o_data_ram_write ? 0 : (o_data_ram_read ? 1 : 2);
            if (str_q.size() == 0) begin
              chk("unexpected_strobe", 64'(kind + 1), 64'(0));
            end else begin
              es = str_q.pop_front();
              chk("strobe_cycle", 64'(cyc), 64'(es.cyc));
              chk("strobe_kind", 64'(kind), 64'(es.kind));
              chk("mem_addr", 64'(o_mem_addr), 64'(es.a));
              if (es.kind == 0) chk("mem_wdata", 64'(o_mem_wdata), 64'(es.d));
            end
          end
          if (o_ack != '0) begin
            if (ack_q.size() == 0) begin
              chk("unexpected_ack", 64'(o_ack), 64'(0));
            end else begin
              ea = ack_q.pop_front();
              chk("ack_cycle", 64'(cyc), 64'(ea.cyc));
              chk("ack_vector", 64'(o_ack), 64'(1) << ea.ch);
              chk("grant_id", 64'(o_grant_id), 64'(ea.ch));
              chk("err", 64'(o_err), 64'(ea.err));
              chk("rdata", 64'(o_rdata), 64'(ea.rdata));
              chk("busy_at_ack", 64'(o_busy), 64'(1));
            end
          end else begin
            chk("err_without_ack", 64'(o_err), 64'(0));
          end
        end
      end
    end
    chk("driver_timeouts", 64'(drv_timeouts), 64'(0));
    chk("ack_queue_drained", 64'(ack_q.size()), 64'(0));
    chk("strobe_queue_drained", 64'(str_q.size()), 64'(0));
`ifdef EXT_BUS_PERF_CNT_EN
    chk("perf_xfers", 64'(o_perf_xfers), 64'(exp_xfers));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- driver + model ----------------
  function automatic txn_t rnd_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.space = ($urandom_range(0, 3) == 0);
    t.a     = AW'($urandom_range(0, 15));
    t.d     = DW'($urandom());
    return t;
  endfunction

  function automatic txn_t mk(input logic w, input logic s, input logic [AW-1:0] a,
                              input logic [DW-1:0] d);
    txn_t t;
    t.we = w; t.space = s; t.a = a; t.d = d;
    return t;
  endfunction

  task automatic put_txn(input int k, input txn_t t);
    we[k]    = t.we;
    space[k] = t.space;
    addr[k*AW +: AW]  = t.a;
    wdata[k*DW +: DW] = t.d;
  endtask

  task automatic run_batch();
    txn_t    mq [NCH][$];
    txn_t    t;
    ackexp_t ea;
    strexp_t es;
    int      T, p, k, acc, ackc, prev;
    logic    first;
    @(posedge clk);
    #1;
    T = cyc;
    for (int c = 0; c < NCH; c++) mq[c] = chq[c];
    p = model_ptr;
    prev = 0;
    first = 1'b1;
    while (1) begin
      k = -1;
      for (int i = 0; i < NCH; i++) begin
        int c;
        c = (p + i) % NCH;
        if (k < 0 && mq[c].size() > 0) k = c;
      end
      if (k < 0) break;
      t = mq[k].pop_front();
      acc = first ? T + 1 : prev + 2;
      first = 1'b0;
      ackc = acc + 1 + (t.we ? 0 : int'(WC));
      prev = ackc;
      ea.err = 1'b0;
      if (t.we && !t.space) begin
        es.cyc = acc; es.kind = 0; es.a = t.a; es.d = t.d;
        str_q.push_back(es);
        ref_ram[t.a] = t.d;
      end else if (t.we) begin
        ea.err = 1'b1;
      end else begin
        es.cyc = acc; es.kind = t.space ? 2 : 1; es.a = t.a; es.d = '0;
        str_q.push_back(es);
        lastrd = t.space ? rom_val(t.a) : ref_ram[t.a];
      end
      ea.cyc = ackc; ea.ch = k; ea.rdata = lastrd;
      ack_q.push_back(ea);
      exp_xfers++;
      p = (k + 1) % NCH;
    end
    model_ptr = p;

    for (int c = 0; c < NCH; c++) begin
      if (chq[c].size() > 0) begin
        put_txn(c, chq[c][0]);
        req[c] = 1'b1;
      end else begin
        put_txn(c, rnd_txn());
        req[c] = 1'b0;
      end
    end
    for (int n = 0; n < 2000 && req != '0; n++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        if (req[c] && o_ack[c]) begin
          t = chq[c].pop_front();
          if (chq[c].size() > 0) put_txn(c, chq[c][0]);
          else req[c] = 1'b0;
        end else if (!req[c]) begin
          put_txn(c, rnd_txn());
        end
      end
    end
    if (req != '0) drv_timeouts++;
    req = '0;
    for (int c = 0; c < NCH; c++) chq[c].delete();
  endtask

  initial begin : global_timeout
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : driver
    int T;
    strexp_t es;
    for (int i = 0; i < 256; i++) ref_ram[i] = ram_init(i);
    lastrd = '0;
    model_ptr = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // All channels requesting continuously: grants rotate 0,1,2,0,1,2.
    for (int c = 0; c < NCH; c++) begin
      chq[c].push_back(mk(1'b0, 1'b0, AW'(c), '0));
      chq[c].push_back(mk(1'b0, 1'b1, AW'(c + 8), '0));
    end
    run_batch();

    // Write then read-back, then a rejected instruction-space write.
    chq[1].push_back(mk(1'b1, 1'b0, 8'h05, 16'h1234));
    chq[1].push_back(mk(1'b0, 1'b0, 8'h05, '0));
    chq[1].push_back(mk(1'b1, 1'b1, 8'h07, 16'hDEAD));
    chq[1].push_back(mk(1'b0, 1'b0, 8'h12, '0));
    run_batch();

    for (int b = 0; b < 30; b++) begin
      for (int c = 0; c < NCH; c++) begin
        int n;
        n = int'($urandom_range(0, 3));
        for (int j = 0; j < n; j++) chq[c].push_back(rnd_txn());
      end
      run_batch();
    end

    // Reset during the WAIT phase of an instruction read aborts it.
    @(posedge clk);
    #1;
    T = cyc;
    put_txn(1, mk(1'b0, 1'b1, 8'h21, '0));
    req[1] = 1'b1;
    es.cyc = T + 1; es.kind = 2; es.a = 8'h21; es.d = '0;
    str_q.push_back(es);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
    lastrd = '0;
    exp_xfers = 0;

    for (int c = NCH - 1; c >= 0; c--) chq[c].push_back(mk(1'b0, 1'b0, AW'(c + 1), '0));
    run_batch();

    for (int b = 0; b < 5; b++) begin
      for (int c = 0; c < NCH; c++) begin
        int n;
        n = int'($urandom_range(0, 2));
        for (int j = 0; j < n; j++) chq[c].push_back(rnd_txn());
      end
      run_batch();
    end

    repeat (4) @(posedge clk);
    done = 1'b1;
  end

endmodule
